icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the instruction-fetch stage and the memory controller.
- Each cycle it takes the fetch stage's requested PC and returns a 32-bit instruction word with a valid flag.
- On a miss it refills a 16-byte line by issuing four word reads to the memory controller, then serves the hit.

---
 rtl/icache_direct.sv | 88 ++++++++
 tb/tb_icache_direct.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with 4-word line refill
module icache_direct #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
);
  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic [1:0] {IDLE, FETCH, GAP} state_t;
  state_t state_q;
  logic [31:2] req_pc_q;
  logic [27:0] miss_base_q;
  logic [1:0] cnt_q;
  logic mc_req_q;
  logic [31:0] mc_addr_q;
  logic [LINES-1:0] valid_q;
  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [31:0] data_q [LINES][4];
  logic [INDEX_BITS-1:0] req_idx, miss_idx;
  logic [TAG_BITS-1:0] req_tag;
  logic hit, unused_lsb;
  assign unused_lsb = ^pc_in[1:0];
  assign mc_req = mc_req_q;
  assign mc_addr = mc_addr_q;
  always_comb begin
    req_idx = req_pc_q[4 +: INDEX_BITS];
    req_tag = req_pc_q[31 -: TAG_BITS];
    miss_idx = miss_base_q[0 +: INDEX_BITS];
    hit = valid_q[req_idx] && tag_q[req_idx] == req_tag;
    instr_valid = state_q == IDLE && hit && !flush;
    instr = instr_valid ? data_q[req_idx][req_pc_q[3:2]] : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_pc_q <= '0;
      miss_base_q <= '0;
      cnt_q <= 2'd0;
      valid_q <= '0;
      mc_req_q <= 1'b0;
      mc_addr_q <= 32'h0;
    end else if (rdy) begin
      req_pc_q <= pc_in[31:2];
      case (state_q)
        IDLE: if (!hit) begin
          miss_base_q <= req_pc_q[31:4];
          cnt_q <= 2'd0;
          mc_req_q <= 1'b1;
          mc_addr_q <= {req_pc_q[31:4], 4'h0};
          state_q <= FETCH;
        end
        FETCH: if (mc_done) begin
          mc_req_q <= 1'b0;
          if (cnt_q == 2'd3) begin
            valid_q[miss_idx] <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
            state_q <= GAP;
          end
        end
        GAP: begin
          mc_req_q <= 1'b1;
          mc_addr_q <= {miss_base_q, cnt_q, 2'b00};
          state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Tag lands with the last word so a partial line never looks valid
  always_ff @(posedge clk) begin
    if (!rst && rdy && state_q == FETCH && mc_done) begin
      data_q[miss_idx][cnt_q] <= mc_data;
      if (cnt_q == 2'd3) tag_q[miss_idx] <= miss_base_q[27 -: TAG_BITS];
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed and randomized checks of icache_direct against a line-level cache model
module tb_icache_direct;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0, mc_done = 1'b0;
  logic [31:0] pc_in = 32'h0, mc_data;
  logic instr_valid, mc_req;
  logic [31:0] instr, mc_addr;
  int n_tests = 0, n_fail = 0;
  bit rand_wait = 0;
  always #5 clk = ~clk;

  icache_direct dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc_in(pc_in), .flush(flush),
    .instr_valid(instr_valid), .instr(instr), .mc_req(mc_req), .mc_addr(mc_addr),
    .mc_done(mc_done), .mc_data(mc_data)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w = {a[31:2], 2'b00};
    return (w[31:4] == 28'h0) ? 32'h1000 + {30'h0, w[3:2]} : (w * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  // memory controller: answers each request after 0..2 wait cycles; garbage data while rdy is low
  logic [31:0] resp_addr = 32'h0;
  int wait_cnt = 0;
  assign mc_data = rdy ? mem_word(resp_addr) : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (rst || !mc_req || mc_done) begin
      mc_done <= 1'b0;
      wait_cnt <= rand_wait ? int'($urandom_range(0, 2)) : 0;
    end else if (wait_cnt == 0) begin
      mc_done <= 1'b1;
      resp_addr <= mc_addr;
    end else wait_cnt <= wait_cnt - 1;
  end

  // reference: which lines are resident, and the refill in flight (base line, words received)
  bit mvalid [64];
  logic [21:0] mtag [64];
  logic [31:0] exp_req = 32'h0;
  bit busy = 0;
  logic [27:0] base = 28'h0;
  int k = 0;
  function automatic bit mhit(input logic [31:0] a);
    return mvalid[a[9:4]] && mtag[a[9:4]] == a[31:10];
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      foreach (mvalid[i]) mvalid[i] = 0;
      busy = 0;
      k = 0;
      exp_req = 32'h0;
    end else if (rdy) begin
      if (busy) begin
        if (mc_done && mc_req) begin
          k++;
          if (k == 4) begin
            mvalid[base[5:0]] = 1;
            mtag[base[5:0]] = base[27:6];
            busy = 0;
          end
        end
      end else if (!mhit(exp_req)) begin
        busy = 1;
        base = exp_req[31:4];
        k = 0;
      end
      exp_req = pc_in;
    end
  end

  logic [31:0] rq [$];
  bit req_prev = 0;
  always @(negedge clk) begin : mon
    bit exp_v;
    if (!rst) begin
      exp_v = !busy && mhit(exp_req) && !flush;
      n_tests++;
      if (instr_valid !== exp_v) begin
        n_fail++;
        $display("FAIL mon_valid pc=%h got %b want %b", exp_req, instr_valid, exp_v);
      end
      if (exp_v) begin
        n_tests++;
        if (instr !== mem_word(exp_req)) begin
          n_fail++;
          $display("FAIL mon_instr pc=%h got %h want %h", exp_req, instr, mem_word(exp_req));
        end
      end
      if (mc_req) begin
        n_tests++;
        if (!busy || mc_addr !== {base, k[1:0], 2'b00}) begin
          n_fail++;
          $display("FAIL mon_mc_addr got %h want %h (refill active %b)", mc_addr, {base, k[1:0], 2'b00}, busy);
        end
      end
      if (mc_req && !req_prev) rq.push_back(mc_addr);
    end
    req_prev = mc_req;
  end

  task automatic drive(input logic [31:0] pc);
    @(posedge clk);
    #1 pc_in = pc;
  endtask

  task automatic next_req(output logic [31:0] a, output bit ok);
    ok = 0;
    a = 32'h0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (rq.size() > 0) begin
        a = rq.pop_front();
        ok = 1;
      end else @(posedge clk);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      ok = instr_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_tests++;
    if (mc_req !== 1'b0 || mc_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mc got req=%b addr=%h want 0/0", mc_req, mc_addr);
    end
  endtask

  task automatic test_cold_start();
    logic [11:0] pat = 12'h0;
    logic [31:0] addrs [$];
    bit ok = 0, prev;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = mc_req;
    end
    if (ok) begin
      pat[0] = 1'b1;
      addrs.push_back(mc_addr);
      prev = 1;
      for (int j = 1; j < 12; j++) begin
        @(negedge clk);
        pat[j] = mc_req;
        if (mc_req && !prev) addrs.push_back(mc_addr);
        prev = mc_req;
      end
    end
    n_tests++;
    if (pat !== 12'h6DB) begin n_fail++; $display("FAIL cold_req_pattern got %h want 6db", pat); end
    n_tests++;
    if (addrs.size() != 4 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8 || addrs[3] !== 32'hC) begin
      n_fail++;
      $display("FAIL cold_addrs got %0d requests want 0,4,8,c", addrs.size());
    end
    n_tests++;
    if (instr_valid !== 1'b1 || instr !== 32'h1000) begin
      n_fail++;
      $display("FAIL cold_first_hit got v=%b %h want 1 00001000", instr_valid, instr);
    end
  endtask

  task automatic test_line_hit();
    drive(32'h4);
    for (int j = 1; j < 4; j++) begin
      drive(j < 3 ? 32'(4 * (j + 1)) : 32'hC);
      @(negedge clk);
      n_tests++;
      if (instr_valid !== 1'b1 || instr !== 32'h1000 + 32'(j) || mc_req !== 1'b0) begin
        n_fail++;
        $display("FAIL line_hit%0d got v=%b %h req=%b want 1 %h 0", j, instr_valid, instr, mc_req, 32'h1000 + 32'(j));
      end
    end
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    n_tests++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_on_hit got %b want 0", instr_valid); end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if (instr_valid !== 1'b1 || instr !== 32'h1003 || mc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL after_flush_hit got v=%b %h want 1 00001003", instr_valid, instr);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] a;
    bit ok;
    rq.delete();
    drive(32'h400);
    next_req(a, ok);
    n_tests++;
    if (!ok || a !== 32'h400) begin n_fail++; $display("FAIL conflict_addr got %h want 00000400", a); end
    wait_valid(ok);
    n_tests++;
    if (!ok || instr !== mem_word(32'h400)) begin n_fail++; $display("FAIL conflict_instr got %h want %h", instr, mem_word(32'h400)); end
    rq.delete();
    drive(32'h0);
    next_req(a, ok);
    n_tests++;
    if (!ok || a !== 32'h0) begin n_fail++; $display("FAIL evicted_addr got %h ok=%b want 00000000", a, ok); end
    wait_valid(ok);
    n_tests++;
    if (!ok || instr !== 32'h1000) begin n_fail++; $display("FAIL evicted_instr got %h want 00001000", instr); end
  endtask

  task automatic test_flush_mid();
    logic [31:0] a;
    logic [95:0] seq;
    bit ok, ok1;
    rq.delete();
    drive(32'h20);
    next_req(a, ok);
    next_req(a, ok1);
    n_tests++;
    if (!ok || !ok1 || a !== 32'h24) begin n_fail++; $display("FAIL flush_second_fetch got %h want 00000024", a); end
    #1 flush = 1'b1;
    pc_in = 32'h40;
    @(negedge clk);
    n_tests++;
    if (instr_valid !== 1'b0 || mc_req !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_mid_cycle got v=%b req=%b want 0 1", instr_valid, mc_req);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    for (int j = 0; j < 3; j++) begin
      next_req(a, ok);
      seq = {seq[63:0], a};
    end
    n_tests++;
    if (seq !== {32'h28, 32'h2C, 32'h40}) begin n_fail++; $display("FAIL flush_refill_seq got %h want 28,2c,40", seq); end
    wait_valid(ok);
    n_tests++;
    if (!ok || instr !== mem_word(32'h40)) begin n_fail++; $display("FAIL flush_redirect_instr got %h want %h", instr, mem_word(32'h40)); end
    drive(32'h24);
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (instr_valid !== 1'b1 || instr !== mem_word(32'h24) || mc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flushed_line_kept got v=%b %h want 1 %h", instr_valid, instr, mem_word(32'h24));
    end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] a;
    logic [95:0] seq;
    bit ok;
    rq.delete();
    drive(32'h80);
    next_req(a, ok);
    #1 rdy = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_tests++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h80 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze%0d got req=%b addr=%h v=%b want 1 00000080 0", j, mc_req, mc_addr, instr_valid);
      end
    end
    @(posedge clk);
    #1 rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      next_req(a, ok);
      seq = {seq[63:0], a};
    end
    n_tests++;
    if (seq !== {32'h84, 32'h88, 32'h8C}) begin n_fail++; $display("FAIL freeze_resume_seq got %h want 84,88,8c", seq); end
    wait_valid(ok);
    n_tests++;
    if (!ok || instr !== mem_word(32'h80)) begin n_fail++; $display("FAIL freeze_instr got %h want %h", instr, mem_word(32'h80)); end
  endtask

  task automatic test_line_cross();
    logic [31:0] a;
    bit ok;
    drive(32'hC);
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (instr_valid !== 1'b1 || instr !== 32'h1003) begin n_fail++; $display("FAIL cross_hit got v=%b %h want 1 00001003", instr_valid, instr); end
    rq.delete();
    drive(32'h10);
    next_req(a, ok);
    n_tests++;
    if (!ok || a !== 32'h10) begin n_fail++; $display("FAIL cross_addr got %h want 00000010", a); end
    wait_valid(ok);
    n_tests++;
    if (!ok || instr !== mem_word(32'h10)) begin n_fail++; $display("FAIL cross_instr got %h want %h", instr, mem_word(32'h10)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    logic [159:0] seq;
    bit ok;
    rq.delete();
    drive(32'h300);
    next_req(a, ok);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    rq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      next_req(a, ok);
      seq = {seq[127:0], a};
    end
    n_tests++;
    if (seq !== {32'h0, 32'h4, 32'h8, 32'hC, 32'h300}) begin
      n_fail++;
      $display("FAIL reset_mid_seq got %h want 0,4,8,c,300", seq);
    end
    wait_valid(ok);
    n_tests++;
    if (!ok || instr !== mem_word(32'h300)) begin n_fail++; $display("FAIL reset_mid_instr got %h want %h", instr, mem_word(32'h300)); end
  endtask

  task automatic test_random();
    bit ok;
    rand_wait = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      case ($urandom_range(0, 2))
        0: begin
          pc_in = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
          if ($urandom_range(0, 9) == 0) pc_in[31:28] = 4'($urandom_range(1, 15));
        end
        1: pc_in = pc_in + 32'h4;
        default: ;
      endcase
      rdy = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 499) == 0;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rdy = 1'b1;
    flush = 1'b0;
    rand_wait = 0;
    drive(32'h14);
    @(posedge clk);
    wait_valid(ok);
    n_tests++;
    if (!ok || instr !== mem_word(32'h14)) begin n_fail++; $display("FAIL random_settle got v=%b %h want %h", ok, instr, mem_word(32'h14)); end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_line_hit();
    test_conflict();
    test_flush_mid();
    test_rdy_freeze();
    test_line_cross();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
